// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read stage and the RV32M multiply/divide unit.
// The master issues operations; the slave (muldiv_unit) returns results.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide.
// Optional MULDIV_FAST_MUL_EN computes multiplies in a single cycle and skips the iteration phase.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic                r_signA;
    logic                r_signB;
    logic [XLEN-1:0]     r_absA;
    logic [XLEN-1:0]     r_absB;
    logic [2*XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rdOut;

    logic                w_start;
    logic                w_signedA;
    logic                w_signedB;
    logic                w_negA;
    logic                w_negB;
    logic [XLEN-1:0]     w_absA;
    logic [XLEN-1:0]     w_absB;
    logic [XLEN:0]       w_mulSum;
    logic [2*XLEN-1:0]   w_mulNext;
    logic [XLEN:0]       w_remShift;
    logic                w_divGe;
    logic [XLEN-1:0]     w_divLo;
    logic [2*XLEN-1:0]   w_divNext;
    logic                w_negProd;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fixed;

    assign w_start   = bus.start && (r_state == IDLE);
    assign w_signedA = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                       (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_signedB = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                       (bus.funct3 == 3'b110);
    assign w_negA    = w_signedA && bus.op_a[XLEN-1];
    assign w_negB    = w_signedB && bus.op_b[XLEN-1];
    assign w_absA    = w_negA ? -bus.op_a : bus.op_a;
    assign w_absB    = w_negB ? -bus.op_b : bus.op_b;

    // Multiply: upper half accumulates the multiplicand, lower half holds the shrinking multiplier.
    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_absA} : '0);
    assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_remShift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_divGe    = w_remShift >= {1'b0, r_absB};
    assign w_divLo    = w_remShift[XLEN-1:0] - r_absB;
    assign w_divNext  = w_divGe ? {w_divLo, r_acc[XLEN-2:0], 1'b1}
                                : {w_remShift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    assign w_negProd = r_signA ^ r_signB;
    assign w_prod    = w_negProd ? -r_acc : r_acc;
    assign w_quo     = r_acc[XLEN-1:0];
    assign w_rem     = r_acc[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_next = bus.funct3[2] ? CALC : FIX;
`else
                    w_next = CALC;
`endif
                end
            end
            CALC:    if (r_cnt == CNT_W'(XLEN-1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A zero divisor leaves an all-ones magnitude quotient, which must not be sign-corrected.
    always_comb begin
        w_fixed = '0;
        case (r_funct3)
            3'b000:                 w_fixed = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fixed = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fixed = (r_absB == '0) ? '1 : (w_negProd ? -w_quo : w_quo);
            default:                w_fixed = r_signA ? -w_rem : w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3 <= '0;
            r_rd     <= '0;
            r_signA  <= 1'b0;
            r_signB  <= 1'b0;
            r_absA   <= '0;
            r_absB   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_rdOut  <= '0;
        end else if (w_start) begin
            r_funct3 <= bus.funct3;
            r_rd     <= bus.rd_in;
            r_signA  <= w_negA;
            r_signB  <= w_negB;
            r_absA   <= w_absA;
            r_absB   <= w_absB;
            r_cnt    <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.funct3[2]) r_acc <= {{XLEN{1'b0}}, w_absA} * {{XLEN{1'b0}}, w_absB};
            else                r_acc <= {{XLEN{1'b0}}, w_absA};
`else
            r_acc    <= {{XLEN{1'b0}}, bus.funct3[2] ? w_absA : w_absB};
`endif
        end else if (r_state == CALC) begin
            r_cnt    <= r_cnt + 1'b1;
            r_acc    <= r_funct3[2] ? w_divNext : w_mulNext;
        end else if (r_state == FIX) begin
            r_result <= w_fixed;
            r_rdOut  <= r_rd;
        end
    end

    assign bus.busy   = (r_state == CALC) || (r_state == FIX);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.rd_out = r_rdOut;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases plus random ops vs. an arithmetic model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          startCycle;
        int          latency;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic prevDone = 1'b0;
    exp_t expQ[$];

    muldiv_unit_if bus();

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model built from the RV32M rules using plain integer arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] f3);
`ifdef MULDIV_FAST_MUL_EN
        return f3[2] ? 33 : 1;
`else
        return (f3 == 3'd7) ? 33 : 33;
`endif
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic waitIdle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL waitIdle: busy=%b done=%b after %0d cycles", bus.busy, bus.done, n);
        end
    endtask

    // Issue one op, push its expected completion, then scramble the inputs to prove they were captured.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        waitIdle();
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        @(negedge clk);
        e.result     = refModel(f3, a, b);
        e.rd         = rd;
        e.startCycle = cycle;
        e.latency    = expLatency(f3);
        expQ.push_back(e);
        bus.start  = 1'b0;
        checkOutput("busyAfterStart", {31'b0, bus.busy}, 32'd1);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.funct3 = 3'($urandom);
        bus.rd_in  = 5'($urandom);
    endtask

    task automatic pulseIgnoredStart();
        bus.start  = 1'b1;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom);
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever done is seen and checks result, rd_out, latency and pulse width.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            prevDone = 1'b0;
        end else begin
            if (prevDone) checkOutput("doneWidth", {31'b0, bus.done}, 32'd0);
            if (bus.done) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedDone: got result %h rd %0d, expected no completion", bus.result, bus.rd_out);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result", bus.result, e.result);
                    checkOutput("rdOut", {27'b0, bus.rd_out}, {27'b0, e.rd});
                    checkOutput("latency", 32'(cycle - e.startCycle), 32'(e.latency));
                end
            end
            prevDone = bus.done;
        end
    end

    initial begin
        int n;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        bus.rd_in  = 5'd0;

        #12;
        checkOutput("resetBusy",   {31'b0, bus.busy}, 32'd0);
        checkOutput("resetDone",   {31'b0, bus.done}, 32'd0);
        checkOutput("resetResult", bus.result, 32'd0);
        checkOutput("resetRdOut",  {27'b0, bus.rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
        applyStimulus(3'd1, 32'h80000000, 32'h80000000, 5'd1);
        applyStimulus(3'd3, 32'h80000000, 32'h80000000, 5'd2);
        applyStimulus(3'd2, 32'h80000000, 32'h80000000, 5'd3);
        applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
        applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd7);
        applyStimulus(3'd7, 32'd100, 32'd7, 5'd8);
        applyStimulus(3'd4, 32'h1234, 32'd0, 5'd9);
        applyStimulus(3'd6, 32'h1234, 32'd0, 5'd10);
        applyStimulus(3'd5, 32'h1234, 32'd0, 5'd11);
        applyStimulus(3'd7, 32'h1234, 32'd0, 5'd12);
        applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13);
        applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14);
        applyStimulus(3'd0, 32'd6, 32'd7, 5'd0);

        applyStimulus(3'd5, 32'd1000, 32'd10, 5'd15);
        repeat (3) @(negedge clk);
        pulseIgnoredStart();

        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        pulseIgnoredStart();
        checkOutput("busyAfterDoneStart", {31'b0, bus.busy}, 32'd0);

        applyStimulus(3'd0, 32'h12345678, 32'h9ABCDEF0, 5'd16);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetBusy",   {31'b0, bus.busy}, 32'd0);
        checkOutput("midResetDone",   {31'b0, bus.done}, 32'd0);
        checkOutput("midResetResult", bus.result, 32'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(3'd7, 32'd50, 32'd7, 5'd17);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 5'($urandom));
        end

        waitIdle();
        repeat (40) @(negedge clk);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
